ps2_kb_rx: RTL

PS/2 device-to-host receiver. It deserialises 11-bit keyboard frames from the external PS/2 clock/data pins into bytes. Each validated byte is delivered as a one-cycle write strobe. Outputs connect directly to the keyboard FIFO write side (rxdata -> wrdata, rx_valid -> wr_en). The block sits between the pin I/O and the keyboard buffer in the core clock domain.

---
 rtl/ps2_kb_rx_pkg.sv | 21 ++
 rtl/ps2_filter.sv | 53 +++++
 rtl/ps2_kb_rx.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ps2_kb_rx_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM state encoding,
// frame geometry and the odd-parity rule used to validate a received byte.
`timescale 1ns/1ps
package ps2_kb_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam int PS2_DATA_BITS = 8;

    // PS/2 frames carry odd parity: data bits plus parity bit hold an odd count of ones.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                           input logic                     parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_filter.sv
// One PS/2 pin: 2-flop synchroniser, then a level filter that only follows the
// pin after FILTER_LEN consecutive differing samples. Emits a 1-cycle fall strobe.
`timescale 1ns/1ps
module ps2_filter
    import ps2_kb_rx_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic level_o,
    output logic fall_o
);

    localparam int            CW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          fall_q;
    logic [CW-1:0] cnt_q;

    // NOTE: every flop here is state, so all assignments are non-blocking; blocking
    // assignments would let sync2_q see this cycle's sync1_q and collapse the synchroniser.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            fall_q  <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
                fall_q  <= ~sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_kb_rx.sv
// PS/2 device-to-host receiver: filtered clock/data in, validated bytes out as
// one-cycle strobes. Define PS2_KB_RX_TIMEOUT_EN to abort stalled frames.
`timescale 1ns/1ps
module ps2_kb_rx
    import ps2_kb_rx_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 57272
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic [7:0] rxdata,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int                     BITCNT_W = $clog2(PS2_DATA_BITS);
    localparam logic [BITCNT_W-1:0]    BIT_LAST = BITCNT_W'(PS2_DATA_BITS - 1);

    if (FILTER_LEN < 2 || FILTER_LEN > 255 || TIMEOUT_CYC < 2) begin : g_bad_param
        $error("ps2_kb_rx: parameter out of range");
    end

    logic unused_fclk_level;
    logic fclk_fall;
    logic fdata;
    logic unused_fdata_fall;

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk     (clk),
        .rst     (rst),
        .pin_i   (ps2_clk_in),
        .level_o (unused_fclk_level),
        .fall_o  (fclk_fall)
    );

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk     (clk),
        .rst     (rst),
        .pin_i   (ps2_data_in),
        .level_o (fdata),
        .fall_o  (unused_fdata_fall)
    );

    ps2_state_e                   state_q;
    logic [BITCNT_W-1:0]          bitcnt_q;
    logic [PS2_DATA_BITS-1:0]     shift_q;
    logic                         parity_q;
    logic [7:0]                   rxdata_q;
    logic                         rx_valid_q;
    logic                         parity_err_q;
    logic                         frame_err_q;
    logic                         busy_q;
    logic                         tmo_hit;

`ifdef PS2_KB_RX_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] tmo_cnt_q;

    // The count reaches TIMEOUT_CYC on this cycle; it overrides a coincident edge.
    assign tmo_hit = (state_q != IDLE) && (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else if (state_q == IDLE || fclk_fall || tmo_hit) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            rxdata_q     <= 8'h00;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (tmo_hit) begin
                state_q     <= IDLE;
                bitcnt_q    <= '0;
                frame_err_q <= 1'b1;
                busy_q      <= 1'b0;
            end else if (fclk_fall) begin
                case (state_q)
                    IDLE: begin
                        // A high data level on an idle edge is noise, not a start bit.
                        if (!fdata) begin
                            state_q  <= DATA;
                            bitcnt_q <= '0;
                            shift_q  <= '0;
                            busy_q   <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift_q  <= {fdata, shift_q[PS2_DATA_BITS-1:1]};
                        bitcnt_q <= bitcnt_q + 1'b1;
                        if (bitcnt_q == BIT_LAST) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_q <= fdata;
                        state_q  <= STOP;
                    end
                    STOP: begin
                        if (!odd_parity_ok(shift_q, parity_q)) begin
                            parity_err_q <= 1'b1;
                        end else if (!fdata) begin
                            frame_err_q <= 1'b1;
                        end else begin
                            rxdata_q   <= shift_q;
                            rx_valid_q <= 1'b1;
                        end
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rxdata     = rxdata_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule
